// File: rtl/masked_share_bundler.sv
// Registered share/public/random bundler: gathers a PRD_W-bit random word from narrow RNG beats
// and emits it with one masked operand per valid/ready beat. Optional: `define SHARE_RECOMBINE_EN.
module masked_share_bundler #(
    parameter int DATA_W   = 8,
    parameter int NSHARES  = 2,
    parameter int OP_W     = 2,
    parameter int PRD_W    = 18,
    parameter int RND_IN_W = 6
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_W-1:0]             data_i,
    input  logic [(NSHARES-1)*DATA_W-1:0] mask_i,
    input  logic [OP_W-1:0]               op_i,
    input  logic                          rnd_valid_i,
    output logic                          rnd_ready_o,
    input  logic [RND_IN_W-1:0]           rnd_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_W*NSHARES-1:0]     shares_o,
    output logic [OP_W-1:0]               op_o,
`ifdef SHARE_RECOMBINE_EN
    output logic [DATA_W-1:0]             dbg_data_o,
`endif
    output logic [PRD_W-1:0]              prd_o
);

    localparam int BEATS = PRD_W / RND_IN_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if ((PRD_W % RND_IN_W) != 0 || NSHARES < 2) begin : g_bad_cfg
            $error("masked_share_bundler: PRD_W must be a multiple of RND_IN_W and NSHARES >= 2");
        end
    endgenerate

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t                      r_state;
    logic [CNT_W-1:0]            r_count;
    logic [PRD_W-1:0]            r_acc;
    logic                        r_out_valid;
    logic [DATA_W*NSHARES-1:0]   r_shares;
    logic [OP_W-1:0]             r_op;
    logic [PRD_W-1:0]            r_prd;

    logic                        w_in_hs;
    logic                        w_out_hs;
    logic                        w_rnd_hs;
    logic                        w_last_beat;
    logic [DATA_W*NSHARES-1:0]   w_shares;

    assign rnd_ready_o = (r_state == S_FILL);
    assign in_ready_o  = (r_state == S_FULL) && !flush_i && (!r_out_valid || out_ready_i);
    assign w_in_hs     = in_valid_i && in_ready_o;
    assign w_out_hs    = r_out_valid && out_ready_i;
    // A beat offered during flush is handshaken but discarded.
    assign w_rnd_hs    = rnd_valid_i && rnd_ready_o && !flush_i;
    assign w_last_beat = (r_count == CNT_W'(BEATS - 1));

    // Regroup so each operand bit carries its data share followed by its mask shares.
    genvar gi, gk;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            assign w_shares[gi*NSHARES] = data_i[gi];
            for (gk = 1; gk < NSHARES; gk++) begin : g_mask
                assign w_shares[gi*NSHARES + gk] = mask_i[(gk-1)*DATA_W + gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_FILL;
            r_count <= '0;
            r_acc   <= '0;
        end else if (flush_i) begin
            r_state <= S_FILL;
            r_count <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_rnd_hs) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (r_count == CNT_W'(k)) begin
                                r_acc[k*RND_IN_W +: RND_IN_W] <= rnd_i;
                            end
                        end
                        if (w_last_beat) begin
                            r_state <= S_FULL;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (w_in_hs) begin
                        r_state <= S_FILL;
                        r_count <= '0;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_shares    <= '0;
            r_op        <= '0;
            r_prd       <= '0;
        end else if (w_in_hs) begin
            r_out_valid <= 1'b1;
            r_shares    <= w_shares;
            r_op        <= op_i;
            r_prd       <= r_acc;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign shares_o    = r_shares;
    assign op_o        = r_op;
    assign prd_o       = r_prd;

`ifdef SHARE_RECOMBINE_EN
    // Unmasked value for simulation sanity checks only; it defeats the masking.
    logic [DATA_W-1:0] w_recomb;
    logic [DATA_W-1:0] r_dbg;

    always_comb begin
        w_recomb = data_i;
        for (int k = 0; k < NSHARES-1; k++) begin
            w_recomb = w_recomb ^ mask_i[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dbg <= '0;
        end else if (w_in_hs) begin
            r_dbg <= w_recomb;
        end
    end

    assign dbg_data_o = r_dbg;
`endif

endmodule

// File: tb/tb_masked_share_bundler.sv
// Bench for masked_share_bundler: directed vector table, reset corner, then random traffic
// checked against a transaction-level model (queue of accepted RNG beats).
module tb_masked_share_bundler;

    localparam int DATA_W   = 8;
    localparam int NSHARES  = 2;
    localparam int OP_W     = 2;
    localparam int PRD_W    = 18;
    localparam int RND_IN_W = 6;
    localparam int BEATS    = PRD_W / RND_IN_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        rnd_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  data = '0;
    logic [7:0]  mask = '0;
    logic [1:0]  op = '0;
    logic [5:0]  rnd = '0;
    logic        in_ready, rnd_ready, out_valid;
    logic [15:0] shares;
    logic [1:0]  op_o;
    logic [17:0] prd;
`ifdef SHARE_RECOMBINE_EN
    logic [7:0]  dbg;
`endif

    int n_chk = 0;
    int n_err = 0;

    masked_share_bundler #(
        .DATA_W(DATA_W), .NSHARES(NSHARES), .OP_W(OP_W), .PRD_W(PRD_W), .RND_IN_W(RND_IN_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data_i(data), .mask_i(mask), .op_i(op),
        .rnd_valid_i(rnd_valid), .rnd_ready_o(rnd_ready), .rnd_i(rnd),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .shares_o(shares), .op_o(op_o),
`ifdef SHARE_RECOMBINE_EN
        .dbg_data_o(dbg),
`endif
        .prd_o(prd)
    );

    always #5 clk = ~clk;

    // Reference model: accepted beats of the word being built, plus the output bundle.
    logic [5:0]  mq[$];
    logic        m_ov;
    logic [15:0] m_sh;
    logic [1:0]  m_op;
    logic [17:0] m_prd;
    logic [7:0]  m_dbg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 1'b0; m_sh = '0; m_op = '0; m_prd = '0; m_dbg = '0;
    endtask

    function automatic logic [17:0] pack_word();
        logic [17:0] w = '0;
        foreach (mq[k]) w = w | (18'(mq[k]) << (k * RND_IN_W));
        return w;
    endfunction

    function automatic logic [15:0] spread(input logic [7:0] d, input logic [7:0] m);
        logic [15:0] r = '0;
        for (int b = 0; b < 8; b++) begin
            r[b*2]     = d[b];
            r[b*2 + 1] = m[b];
        end
        return r;
    endfunction

    // Inputs are already driven; check readies, take one edge, update model, check outputs.
    task automatic cycle(output logic s_rr, output logic s_ir);
        logic full, e_rr, e_ir, ih, oh;
        #1;
        full = (mq.size() == BEATS);
        e_rr = !full;
        e_ir = full && !flush && (!m_ov || out_ready);
        s_rr = rnd_ready;
        s_ir = in_ready;
        chk("rnd_ready", rnd_ready, e_rr);
        chk("in_ready", in_ready, e_ir);
        ih = in_valid && e_ir;
        oh = m_ov && out_ready;
        @(posedge clk);
        #1;
        if (ih) begin
            m_prd = pack_word();
            m_sh  = spread(data, mask);
            m_op  = op;
            m_dbg = data ^ mask;
            m_ov  = 1'b1;
            mq.delete();
        end else if (oh) begin
            m_ov = 1'b0;
        end
        if (flush) mq.delete();
        else if (!full && rnd_valid) mq.push_back(rnd);
        chk("out_valid", out_valid, m_ov);
        chk("shares", shares, m_sh);
        chk("op_o", op_o, m_op);
        chk("prd", prd, m_prd);
`ifdef SHARE_RECOMBINE_EN
        chk("dbg_data", dbg, m_dbg);
`endif
    endtask

    typedef struct {
        logic fl, iv, rv; logic [5:0] rn; logic ordy;
        logic [7:0] d, m; logic [1:0] o;
        logic xrr, xir, xov; logic [17:0] xprd; logic [1:0] xop, xlo, xhi;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic s_rr, s_ir;

        // fl iv rv rn  ordy d  m  o   xrr xir xov xprd  xop xlo xhi
        tbl[0]  = '{0,0,1,6'h01,1,8'h00,8'h00,2'd0, 1,0,0,18'h00000,2'd0,2'd0,2'd0};
        tbl[1]  = '{0,0,1,6'h02,1,8'h00,8'h00,2'd0, 1,0,0,18'h00000,2'd0,2'd0,2'd0};
        tbl[2]  = '{0,0,1,6'h03,1,8'h00,8'h00,2'd0, 1,0,0,18'h00000,2'd0,2'd0,2'd0};
        tbl[3]  = '{0,1,0,6'h00,1,8'hA5,8'h3C,2'd2, 0,1,1,18'h03081,2'd2,2'd1,2'd1};
        tbl[4]  = '{0,0,1,6'h11,0,8'h00,8'h00,2'd0, 1,0,1,18'h03081,2'd2,2'd1,2'd1};
        tbl[5]  = '{0,0,1,6'h22,0,8'h00,8'h00,2'd0, 1,0,1,18'h03081,2'd2,2'd1,2'd1};
        tbl[6]  = '{0,0,1,6'h33,0,8'h00,8'h00,2'd0, 1,0,1,18'h03081,2'd2,2'd1,2'd1};
        tbl[7]  = '{0,1,0,6'h00,0,8'h0F,8'hF0,2'd1, 0,0,1,18'h03081,2'd2,2'd1,2'd1};
        tbl[8]  = '{0,1,0,6'h00,1,8'h0F,8'hF0,2'd1, 0,1,1,18'h33891,2'd1,2'd1,2'd2};
        tbl[9]  = '{0,1,1,6'h01,1,8'h5A,8'h00,2'd3, 1,0,0,18'h33891,2'd1,2'd1,2'd2};
        tbl[10] = '{0,1,1,6'h02,1,8'h5A,8'h00,2'd3, 1,0,0,18'h33891,2'd1,2'd1,2'd2};
        tbl[11] = '{0,1,1,6'h04,1,8'h5A,8'h00,2'd3, 1,0,0,18'h33891,2'd1,2'd1,2'd2};
        tbl[12] = '{0,1,1,6'h3F,1,8'h5A,8'h00,2'd3, 0,1,1,18'h04081,2'd3,2'd0,2'd0};
        tbl[13] = '{0,0,1,6'h05,1,8'h00,8'h00,2'd0, 1,0,0,18'h04081,2'd3,2'd0,2'd0};
        tbl[14] = '{0,0,1,6'h06,1,8'h00,8'h00,2'd0, 1,0,0,18'h04081,2'd3,2'd0,2'd0};
        tbl[15] = '{1,0,1,6'h07,1,8'h00,8'h00,2'd0, 1,0,0,18'h04081,2'd3,2'd0,2'd0};
        tbl[16] = '{0,0,1,6'h08,1,8'h00,8'h00,2'd0, 1,0,0,18'h04081,2'd3,2'd0,2'd0};
        tbl[17] = '{0,0,1,6'h09,1,8'h00,8'h00,2'd0, 1,0,0,18'h04081,2'd3,2'd0,2'd0};
        tbl[18] = '{0,0,1,6'h0A,1,8'h00,8'h00,2'd0, 1,0,0,18'h04081,2'd3,2'd0,2'd0};
        tbl[19] = '{0,1,0,6'h00,1,8'hFF,8'h00,2'd0, 0,1,1,18'h0A248,2'd0,2'd1,2'd1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_prd", prd, 18'h0);
        chk("rst_shares", shares, 16'h0);
        chk("rst_rnd_ready", rnd_ready, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            flush = tbl[i].fl; in_valid = tbl[i].iv; rnd_valid = tbl[i].rv; rnd = tbl[i].rn;
            out_ready = tbl[i].ordy; data = tbl[i].d; mask = tbl[i].m; op = tbl[i].o;
            cycle(s_rr, s_ir);
            chk("tv_rnd_ready", s_rr, tbl[i].xrr);
            chk("tv_in_ready", s_ir, tbl[i].xir);
            chk("tv_out_valid", out_valid, tbl[i].xov);
            chk("tv_prd", prd, tbl[i].xprd);
            chk("tv_op", op_o, tbl[i].xop);
            chk("tv_shares_lo", shares[1:0], tbl[i].xlo);
            chk("tv_shares_hi", shares[15:14], tbl[i].xhi);
            $display("vec %0d: rr=%b ir=%b ov=%b prd=%05h op=%0d shares=%04h",
                     i, s_rr, s_ir, out_valid, prd, op_o, shares);
        end

        // Async reset while a bundle is held and a new word is part-filled.
        flush = 0; in_valid = 0; out_ready = 0; rnd_valid = 1; rnd = 6'h15;
        cycle(s_rr, s_ir);
        rnd_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_prd", prd, 18'h0);
        chk("arst_shares", shares, 16'h0);
        chk("arst_op", op_o, 2'd0);
        chk("arst_rnd_ready", rnd_ready, 1'b1);
        #1;
        rst_n = 1'b1;
        #1;
        out_ready = 1; rnd_valid = 1;
        for (int k = 0; k < BEATS; k++) begin
            rnd = 6'(6'h21 + k);
            cycle(s_rr, s_ir);
        end
        rnd_valid = 0; in_valid = 1; data = 8'h81; mask = 8'h7E; op = 2'd1;
        cycle(s_rr, s_ir);
        chk("post_rst_prd", prd, 18'h238A1);
        $display("post-reset bundle: prd=%05h shares=%04h", prd, shares);
        in_valid = 0;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            rnd_valid = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            rnd       = 6'($urandom);
            data      = 8'($urandom);
            mask      = 8'($urandom);
            op        = 2'($urandom);
            cycle(s_rr, s_ir);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
